// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round-key type, scheduler FSM states and
// the byte-level S-box used by the key expansion stage.
package aes_pkg;
    localparam int KEY_W  = 128;
    localparam int NUM_RK = 11;

    typedef logic [KEY_W-1:0] round_key_t;
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (square-and-multiply), then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction
endpackage

// File: rtl/key_expansion.sv
// One AES-128 key expansion round: next 4 words from the current round key.
module key_expansion
    import aes_pkg::*;
(
    input  round_key_t  key,
    input  logic [3:0]  count,
    output round_key_t  key_out
);
    logic [7:0]  w_rcon;
    logic [31:0] w_rot, w_temp;
    logic [31:0] w_w4, w_w5, w_w6, w_w7;

    always_comb begin
        w_rcon = 8'h00;
        case (count)
            4'd0: w_rcon = 8'h01;
            4'd1: w_rcon = 8'h02;
            4'd2: w_rcon = 8'h04;
            4'd3: w_rcon = 8'h08;
            4'd4: w_rcon = 8'h10;
            4'd5: w_rcon = 8'h20;
            4'd6: w_rcon = 8'h40;
            4'd7: w_rcon = 8'h80;
            4'd8: w_rcon = 8'h1b;
            4'd9: w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_rot  = {key[23:0], key[31:24]};
    assign w_temp = {sbox(w_rot[31:24]) ^ w_rcon, sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    assign w_w4   = key[127:96] ^ w_temp;
    assign w_w5   = w_w4 ^ key[95:64];
    assign w_w6   = w_w5 ^ key[63:32];
    assign w_w7   = w_w6 ^ key[31:0];
    assign key_out = {w_w4, w_w5, w_w6, w_w7};
endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 round-key scheduler: one expansion round per clock,
// all 11 keys held in registers and served through a 1-cycle read port.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  round_key_t  key_in,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        rk_rd,
    input  logic [3:0]  rk_idx,
    output round_key_t  rk_out,
    output logic        rk_out_valid,
    output logic        sched_done,
    output logic        busy
);
    if (NUM_ROUNDS != 10) begin : g_bad_cfg
        $error("aes_key_schedule supports only NUM_ROUNDS = 10");
    end

    ks_state_t  r_state, w_state_nxt;
    logic [3:0] r_count;
    round_key_t r_cur;
    round_key_t r_rk [NUM_RK];
    round_key_t r_rk_out;
    logic       r_rk_out_valid, r_sched_done, r_busy;
    round_key_t w_key_out, w_rd_data;
    logic       w_accept, w_last;

    key_expansion u_kexp (
        .key     (r_cur),
        .count   (r_count),
        .key_out (w_key_out)
    );

    assign key_ready    = (r_state != EXPAND);
    assign w_accept     = key_valid && key_ready;
    assign w_last       = (r_count == 4'(NUM_ROUNDS - 1));
    assign rk_out       = r_rk_out;
    assign rk_out_valid = r_rk_out_valid;
    assign sched_done   = r_sched_done;
    assign busy         = r_busy;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = EXPAND;
            EXPAND:  if (w_last)   w_state_nxt = DONE;
            DONE:    if (w_accept) w_state_nxt = EXPAND;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Out-of-range indices read as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_RK; i++)
            if (rk_idx == 4'(i)) w_rd_data = r_rk[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_cur          <= '0;
            r_rk_out       <= '0;
            r_rk_out_valid <= 1'b0;
            r_sched_done   <= 1'b0;
            r_busy         <= 1'b0;
            for (int i = 0; i < NUM_RK; i++) r_rk[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rk[0]      <= key_in;
                r_cur        <= key_in;
                r_count      <= '0;
                r_sched_done <= 1'b0;
                r_busy       <= 1'b1;
            end else if (r_state == EXPAND) begin
                for (int i = 1; i < NUM_RK; i++)
                    if (r_count == 4'(i - 1)) r_rk[i] <= w_key_out;
                r_cur   <= w_key_out;
                r_count <= r_count + 4'd1;
                if (w_last) begin
                    r_busy       <= 1'b0;
                    r_sched_done <= 1'b1;
                end
            end
            // Reads see pre-edge contents, so a same-cycle re-key returns the old keys.
            if (rk_rd && r_sched_done) begin
                r_rk_out       <= w_rd_data;
                r_rk_out_valid <= 1'b1;
            end else begin
                r_rk_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 and all-zero key vectors.
module tb_aes_key_schedule;
    import aes_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    round_key_t  key_in;
    logic        key_valid, key_ready;
    logic        rk_rd;
    logic [3:0]  rk_idx;
    round_key_t  rk_out;
    logic        rk_out_valid, sched_done, busy;

    int n_chk = 0;
    int n_bad = 0;

    round_key_t fips_rk [NUM_RK];
    localparam round_key_t KF = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam round_key_t Z1 = 128'h62636363626363636263636362636363;
    localparam round_key_t Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_schedule #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .rk_rd(rk_rd), .rk_idx(rk_idx), .rk_out(rk_out),
        .rk_out_valid(rk_out_valid), .sched_done(sched_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for sched_done after an accept; returns edges counted.
    task automatic wait_done(output int n);
        n = 0;
        while (!sched_done && n < 20) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        fips_rk[0]  = KF;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; key_in = '0; key_valid = 1'b0; rk_rd = 1'b0; rk_idx = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", key_ready, 1);
        chk("rst_done", sched_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rkout", rk_out, 0);
        chk("rst_rkvld", rk_out_valid, 0);

        // FIPS key; during EXPAND hold a different key valid and request reads.
        key_in = KF; key_valid = 1'b1;
        tick();
        chk("acc_busy", busy, 1);
        chk("acc_ready", key_ready, 0);
        key_in = '0; rk_rd = 1'b1; rk_idx = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("exp_ready%0d", i), key_ready, 0);
            chk($sformatf("exp_vld%0d", i), rk_out_valid, 0);
            chk($sformatf("exp_done%0d", i), sched_done, 0);
        end
        key_valid = 1'b0; rk_rd = 1'b0;
        tick();
        chk("f_done_t10", sched_done, 1);
        chk("f_busy_t10", busy, 0);
        chk("f_ready_t10", key_ready, 1);
        chk("f_rkout_held", rk_out, 0);

        // Back-to-back reads 0..10, then out-of-range 11 and 15.
        for (int i = 0; i < NUM_RK; i++) begin
            rk_rd = 1'b1; rk_idx = 4'(i);
            tick();
            chk($sformatf("f_rk%0d", i), rk_out, fips_rk[i]);
            chk($sformatf("f_vld%0d", i), rk_out_valid, 1);
        end
        rk_idx = 4'd11;
        tick();
        chk("oor11_rk", rk_out, 0);
        chk("oor11_vld", rk_out_valid, 1);
        rk_idx = 4'd15;
        tick();
        chk("oor15_rk", rk_out, 0);
        chk("oor15_vld", rk_out_valid, 1);
        rk_rd = 1'b0;
        tick();
        chk("idle_vld", rk_out_valid, 0);

        // Re-key with zero key while reading idx 0 in the same cycle.
        key_in = '0; key_valid = 1'b1; rk_rd = 1'b1; rk_idx = 4'd0;
        tick();
        chk("rekey_old_rk0", rk_out, KF);
        chk("rekey_vld", rk_out_valid, 1);
        chk("rekey_done_drop", sched_done, 0);
        chk("rekey_busy", busy, 1);
        key_valid = 1'b0; rk_rd = 1'b0;
        wait_done(n);
        chk("z_latency", n, 10);
        rk_rd = 1'b1; rk_idx = 4'd1;
        tick();
        chk("z_rk1", rk_out, Z1);
        rk_idx = 4'd0;
        tick();
        chk("z_rk0", rk_out, 0);
        rk_idx = 4'd10;
        tick();
        chk("z_rk10", rk_out, Z10);
        rk_rd = 1'b0;

        // Reset at count = 5 during a FIPS reload.
        key_in = KF; key_valid = 1'b1;
        tick();
        key_valid = 1'b0; rk_rd = 1'b1; rk_idx = 4'd3;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_rkout_hold", rk_out, Z10);
        chk("mid_vld", rk_out_valid, 0);
        rst = 1'b1; rk_rd = 1'b0;
        tick();
        rst = 1'b0;
        chk("mrst_ready", key_ready, 1);
        chk("mrst_done", sched_done, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_rkout", rk_out, 0);
        rk_rd = 1'b1; rk_idx = 4'd0;
        tick();
        chk("mrst_rd_ignored", rk_out_valid, 0);
        rk_rd = 1'b0;

        // Reload after reset completes normally.
        key_in = KF; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        wait_done(n);
        chk("rl_latency", n, 10);
        rk_rd = 1'b1; rk_idx = 4'd10;
        tick();
        chk("rl_rk10", rk_out, fips_rk[10]);
        rk_idx = 4'd5;
        tick();
        chk("rl_rk5", rk_out, fips_rk[5]);
        rk_rd = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential AES-128 round-key scheduler. It accepts a 128-bit cipher key through a valid/ready handshake and iterates the single-round `key_expansion` stage once per clock to produce round keys 0..10. It stores all 11 keys and serves them to the downstream round datapath through a registered indexed read port. It sits between the key source (host or key register) and the encryption/decryption round logic.

## Interface
- `NUM_ROUNDS`, default 10: number of expansion rounds. Only 10 (AES-128) is supported; any other value is a configuration error.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in 128: cipher key; word 0 is bits [127:96].
- `key_valid` in 1: `key_in` is valid.
- `key_ready` out 1: block can accept a key.
- `rk_rd` in 1: round-key read request.
- `rk_idx` in 4: round-key index, 0..10.
- `rk_out` out 128: registered round key.
- `rk_out_valid` out 1: `rk_out` was updated this cycle.
- `sched_done` out 1: all 11 round keys are valid.
- `busy` out 1: expansion in progress.

## Operation
- FSM states: IDLE, EXPAND, DONE.
- Reset values:
  - state = IDLE, `count` = 0, all 11 storage entries = 0.
  - `rk_out` = 0, `rk_out_valid` = 0, `sched_done` = 0, `busy` = 0.
  - `key_ready` = 1 in the first cycle after reset.
- `key_ready` is 1 in IDLE and DONE, 0 in EXPAND. A key is accepted when `key_valid` and `key_ready` are both 1 at a clock edge.
- On accept:
  - `rk[0]` <= `key_in`; `cur` <= `key_in`; `count` <= 0; state <= EXPAND.
  - `sched_done` <= 0; `busy` <= 1.
- Each EXPAND cycle:
  - `key_expansion` is driven with `key` = `cur` and `count` = `count`.
  - `rk[count+1]` <= `key_out`; `cur` <= `key_out`; `count` <= `count`+1.
- When `count` == 9: `rk[10]` is written, then state <= DONE, `busy` <= 0, `sched_done` <= 1.
- `count` is 4 bits. Values 10..15 are never presented to `key_expansion`; the rcon default of 0 is unreachable.
- Reads:
  - When `rk_rd` = 1 and `sched_done` = 1: `rk_out` <= `rk[rk_idx]` and `rk_out_valid` <= 1.
  - If `rk_idx` > 10: `rk_out` <= 0 and `rk_out_valid` <= 1.
  - If `rk_rd` = 1 while `sched_done` = 0: the request is ignored, `rk_out` holds, `rk_out_valid` <= 0.
  - `rk_out_valid` is low in every cycle without a served read.
- Re-key in DONE: accepting a new key restarts expansion; `sched_done` drops the cycle after the accept.
- A read and a key accept in the same DONE cycle: the read returns the pre-edge (old) array contents, including the old `rk[0]`.
- `key_valid` during EXPAND is not accepted; the source must hold the key until `key_ready`.
- `rst` mid-expansion: the block returns to the reset state on that edge. Partial keys are discarded and `sched_done` stays 0.

## Timing
- Accept edge T0. `rk[n]` is written at edge Tn for n = 1..10.
- `sched_done` and `busy` = 0 are visible from the cycle after T10: 10 cycles from accept to done.
- Read latency: 1 cycle. `rk_rd` sampled at edge T gives `rk_out`/`rk_out_valid` valid after T.
- Back-to-back reads are supported every cycle.
- Combinational path per cycle: one `key_expansion` (4 S-box lookups + XOR chain) from the `cur` register to the `cur`/storage register.

## Structure
- Shared package `aes_pkg`:
  - `KEY_W` = 128, `NUM_RK` = 11.
  - Typedef `round_key_t` = logic [127:0].
  - FSM state enum `ks_state_t` {IDLE, EXPAND, DONE}.
- One sub-module: the existing `key_expansion` (ports `key`, `count`, `key_out`), instantiated once and reused every cycle.
- Storage: an 11-entry register array (not RAM), so simultaneous write and read are well defined.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> `sched_done` 10 cycles after accept; `rk[1]` = a0fafe1788542cb123a339392a6c7605; `rk[10]` = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key -> `rk[1]` = 62636363626363636263636362636363; `rk[10]` = b4ef5bcb3e92e21123e951cf6f8f188e.
- Read `rk_idx` = 0..10 back to back, then 11 and 15 -> 11 correct keys, one per cycle, at 1-cycle latency; then 0 with `rk_out_valid` = 1 for each out-of-range read.
- `rk_rd` during EXPAND, and `key_valid` held during EXPAND -> no `rk_out_valid`, `key_ready` = 0, no second accept until DONE.
- In DONE, load the zero key while reading `rk_idx` = 0 in the same cycle -> read returns 2b7e...4f3c; `sched_done` drops next cycle and rises 10 cycles later with the zero-key schedule.
- Assert `rst` at EXPAND `count` = 5 -> next cycle: IDLE, `key_ready` = 1, `sched_done` = 0, `rk_out` = 0; a reload then completes normally.
